// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the shift sequencer: command opcodes, FSM states and
// datapath mode selects.
// Optional feature macro: SHIFT_SEQ_CTRL_ROTATE_EN (enables the rotate op).
package shift_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_ROT  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROT  = 3'd4
    } mode_e;

`ifdef SHIFT_SEQ_CTRL_ROTATE_EN
    localparam bit ROTATE_EN = 1'b1;
`else
    localparam bit ROTATE_EN = 1'b0;
`endif

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Command handshake plus serial/parallel status bundle of the shift sequencer.
// The slave modport is the sequencer's view; master is the requester's view.
// Optional feature macro: SHIFT_SEQ_CTRL_ROTATE_EN (no effect on this file).
interface shift_seq_ctrl_if #(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
);
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [1:0]       i_cmd_op;
    logic [CNT_W-1:0] i_cmd_cnt;
    logic [N-1:0]     i_cmd_data;
    logic             i_ser_in;
    logic [N-1:0]     o_q;
    logic             o_ser_out;
    logic             o_busy;
    logic             o_done;

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_cnt, i_cmd_data, i_ser_in,
        output o_cmd_ready, o_q, o_ser_out, o_busy, o_done
    );

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_cnt, i_cmd_data, i_ser_in,
        input  o_cmd_ready, o_q, o_ser_out, o_busy, o_done
    );
endinterface

// File: rtl/shift_seq_dp.sv
// N-bit universal shift register: hold, parallel load, shift left/right with a
// serial fill bit, and (optionally) rotate left. The bit leaving the register
// on each step is captured into a registered serial output that holds between
// steps.
// Optional feature macro: SHIFT_SEQ_CTRL_ROTATE_EN (adds the rotate path).
module shift_seq_dp
    import shift_seq_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  mode_e        i_mode,
    input  logic [N-1:0] i_load_data,
    input  logic         i_ser_in,
    output logic [N-1:0] o_q,
    output logic         o_ser_out
);

    logic [N-1:0] q_q;
    logic         ser_q;

    // Register update: one operation per edge, reset clears both register and serial bit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_q   <= '0;
            ser_q <= 1'b0;
        end else begin
            case (i_mode)
                MODE_LOAD: begin
                    q_q <= i_load_data;
                end
                MODE_SHL: begin
                    q_q   <= {q_q[N-2:0], i_ser_in};
                    ser_q <= q_q[N-1];
                end
                MODE_SHR: begin
                    q_q   <= {i_ser_in, q_q[N-1:1]};
                    ser_q <= q_q[0];
                end
`ifdef SHIFT_SEQ_CTRL_ROTATE_EN
                MODE_ROT: begin
                    q_q   <= {q_q[N-2:0], q_q[N-1]};
                    ser_q <= q_q[N-1];
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign o_q       = q_q;
    assign o_ser_out = ser_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command-driven sequencer around shift_seq_dp. Accepts one command per
// valid/ready handshake in IDLE, steps the register once per clock in SHIFT,
// and spends exactly one cycle in DONE pulsing o_done before returning to IDLE.
// Optional feature macro: SHIFT_SEQ_CTRL_ROTATE_EN. When undefined, op ROT is
// accepted but completes as a no-op without entering SHIFT.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    shift_seq_ctrl_if.slave bus
);

    state_e           state_q;
    op_e              op_q;
    logic [CNT_W-1:0] stepCnt_q;
    logic             done_q;

    op_e              cmdOp;
    logic             cmdAccept;
    logic [CNT_W-1:0] cntClamped;
    logic             opShifts;
    logic             goShift;
    mode_e            mode;

    assign cmdOp      = op_e'(bus.i_cmd_op);
    assign cmdAccept  = bus.i_cmd_valid & (state_q == ST_IDLE);
    assign cntClamped = (bus.i_cmd_cnt > CNT_W'(N)) ? CNT_W'(N) : bus.i_cmd_cnt;
    assign opShifts   = (cmdOp == OP_SHL) | (cmdOp == OP_SHR) | ((cmdOp == OP_ROT) & ROTATE_EN);
    assign goShift    = opShifts & (cntClamped != '0);

    // Datapath mode: load on a LOAD accept, step with the captured op while in SHIFT
    always_comb begin
        mode = MODE_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (cmdAccept && (cmdOp == OP_LOAD)) begin
                    mode = MODE_LOAD;
                end
            end
            ST_SHIFT: begin
                case (op_q)
                    OP_SHL:  mode = MODE_SHL;
                    OP_SHR:  mode = MODE_SHR;
                    OP_ROT:  mode = MODE_ROT;
                    default: mode = MODE_HOLD;
                endcase
            end
            default: begin
                mode = MODE_HOLD;
            end
        endcase
    end

    // Sequencer FSM with step counter and registered done pulse; reset wins over a handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD;
            stepCnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (cmdAccept) begin
                        op_q <= cmdOp;
                        if (goShift) begin
                            stepCnt_q <= cntClamped;
                            state_q   <= ST_SHIFT;
                        end else begin
                            stepCnt_q <= '0;
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    stepCnt_q <= stepCnt_q - CNT_W'(1);
                    if (stepCnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    stepCnt_q <= '0;
                    done_q    <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    stepCnt_q <= '0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    shift_seq_dp #(
        .N(N)
    ) u_dp (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_mode     (mode),
        .i_load_data(bus.i_cmd_data),
        .i_ser_in   (bus.i_ser_in),
        .o_q        (bus.o_q),
        .o_ser_out  (bus.o_ser_out)
    );

    assign bus.o_cmd_ready = (state_q == ST_IDLE);
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_done      = done_q;

endmodule
